// File: rtl/game_input_ctrl.sv
// game_input_ctrl: syncs/debounces 5 buttons into rotate/key/decide controls; define KEY_REPEAT_EN for left/right auto-repeat
module game_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_RATE     = 6500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up_in,
    input  logic       btn_down_in,
    input  logic       btn_left_in,
    input  logic       btn_right_in,
    input  logic       btn_center_in,
    output logic [1:0] rotate_out,
    output logic [1:0] key_input_out,
    output logic       decide_out,
    output logic       any_pressed_out
);
    localparam int DW = DEBOUNCE_CYCLES > 2 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] TERM = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("game_input_ctrl: cycle parameters must be >= 1");
    end

    logic [4:0] raw, sync1_q, sync2_q, stable_q, stable_d, stable_prev_q, press;
    logic [4:0][DW-1:0] cnt_q, cnt_d;
    logic [1:0] rotate_q, rotate_d, key_q, key_d, key_press;
    logic decide_q, decide_d, any_q, any_d;

    assign raw = {btn_center_in, btn_right_in, btn_left_in, btn_down_in, btn_up_in};

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            cnt_d[i]    = (sync2_q[i] != stable_q[i] && cnt_q[i] != TERM) ? cnt_q[i] + 1'b1 : '0;
            stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == TERM) ? ~stable_q[i] : stable_q[i];
        end
        press     = stable_q & ~stable_prev_q;
        rotate_d  = press[0] ? 2'b00 : press[3] ? 2'b01 : press[1] ? 2'b10 : press[2] ? 2'b11 : rotate_q;
        key_press = (press[2] & ~press[3]) ? 2'b01 : (press[3] & ~press[2]) ? 2'b10 : 2'b00;
        decide_d  = press[4];
        any_d     = |stable_q;
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW = RMAX > 2 ? $clog2(RMAX) : 1;
    logic [HW-1:0] hold_q, hold_d;
    logic rep_on_q, rep_on_d, rate_q, rate_d, held, fire;

    always_comb begin
        held     = stable_q[2] ^ stable_q[3];
        fire     = rep_on_q & held & (hold_q == (rate_q ? HW'(REPEAT_RATE - 1) : HW'(REPEAT_DELAY - 1)));
        rep_on_d = (key_press != 2'b00) ? held : rep_on_q & held;
        hold_d   = (key_press != 2'b00 || fire || !rep_on_d) ? '0 : hold_q + 1'b1;
        rate_d   = (key_press != 2'b00 || !rep_on_d) ? 1'b0 : fire ? 1'b1 : rate_q;
        key_d    = (key_press != 2'b00) ? key_press : fire ? (stable_q[3] ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q   <= '0;
            rep_on_q <= 1'b0;
            rate_q   <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            rep_on_q <= rep_on_d;
            rate_q   <= rate_d;
        end
    end
`else
    assign key_d = key_press;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
            rotate_q      <= '0;
            key_q         <= '0;
            decide_q      <= 1'b0;
            any_q         <= 1'b0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            rotate_q      <= rotate_d;
            key_q         <= key_d;
            decide_q      <= decide_d;
            any_q         <= any_d;
        end
    end

    assign rotate_out      = rotate_q;
    assign key_input_out   = key_q;
    assign decide_out      = decide_q;
    assign any_pressed_out = any_q;
endmodule
